fpmul_rr_arbiter: RTL
=====================

Name: fpmul_rr_arbiter

Overview:
- Shares one pipelined single-precision FP multiplier (fixed latency, no enable, no valid) between N_REQ requesters.
- Each requester has its own valid/ready request channel and its own valid/ready response channel.
- A round-robin arbiter issues one multiply per cycle.
- A tag shift register follows each operation through the multiplier pipeline and routes the result back to the requester that issued it.
- Sits between the test/driver interfaces and the multiplier instance, replacing single-user sequencing.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 32, operand/result width (IEEE-754 single)
- PIPE_LAT, 4, clock edges from a mul_a/mul_b update to mul_z being valid for capture

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request valid per requester
- req_ready  out  N_REQ  request accepted (grant) per requester
- req_a  in  N_REQ*DW  operand A, requester i at bits [i*DW +: DW]
- req_b  in  N_REQ*DW  operand B, same packing
- rsp_valid  out  N_REQ  result valid per requester
- rsp_ready  in  N_REQ  result consumed per requester
- rsp_data  out  N_REQ*DW  result, same packing
- mul_a  out  DW  registered operand A to multiplier
- mul_b  out  DW  registered operand B to multiplier
- mul_z  in  DW  multiplier result

Behaviour:
- Per-requester FSM with states IDLE, INFLIGHT, HOLD. At most one outstanding op per requester.
- Eligible(i) = state[i]==IDLE && req_valid[i].
- Round-robin pointer last_gnt (reset N_REQ-1):
  - The winner is the first eligible index scanning last_gnt+1, last_gnt+2, … modulo N_REQ.
  - req_ready is one-hot for the winner and combinational. It is 0 for everyone when no requester is eligible.
- Accept edge (req_valid[i] && req_ready[i]):
  - mul_a <= req_a[i], mul_b <= req_b[i].
  - tag pipe stage 0 <= {1, i}.
  - state[i] <= INFLIGHT; last_gnt <= i.
- With no accept, mul_a and mul_b hold their value and stage 0 valid <= 0.
- Tag pipe: PIPE_LAT stages of {valid, idx}, shifting every cycle.
- When the last stage is valid with idx j, the capture happens on the next edge:
  - rsp_data[j] <= mul_z.
  - state[j] <= HOLD; rsp_valid[j] <= 1.
  - rsp_valid[j] therefore rises exactly PIPE_LAT cycles after the accept edge.
- HOLD: rsp_valid[i] and rsp_data[i] are stable until rsp_ready[i]. On that edge rsp_valid[i] <= 0 and state[i] <= IDLE.
- A requester is not eligible in the cycle its response handshakes; it is eligible from the next cycle.
- Throughput: up to N_REQ ops in flight, one issue per cycle.
  - Back-to-back issues to distinct requesters with no bubble.
  - A single requester issues at most once per PIPE_LAT+2 cycles.
- A capture into j and an accept from k≠j in the same cycle are independent. A capture and an accept for the same index cannot coincide.
- rsp_ready for a requester not in HOLD is ignored. req_a/req_b of non-winners are ignored.
- Reset values: req_ready=0 (while rst high), rsp_valid=0, rsp_data=0, mul_a=0, mul_b=0, all tag valids 0, all states IDLE, last_gnt=N_REQ-1.
- Reset mid-operation discards all in-flight tags and held results. Multiplier outputs draining after reset are never captured.
- Arithmetic is done only by the multiplier; this block does not modify data.

Optional Feature:
- Macro: FPMUL_ARB_STATS_EN.
- When defined, the block adds output ports:
  - issue_cnt[31:0]: accepted ops, wraps.
  - stall_cnt[31:0]: cycles where some req_valid[i]=1 with state[i]==IDLE and req_ready[i]=0, wraps.
  - Both counters are cleared by rst.
- When defined, the block also prints one $display line per capture with requester index, mul_z in %h and %f, and the cycle count.
- When undefined, none of these ports or logic exist and the port list is exactly as above.

Test Plan:
- Single op, PIPE_LAT=4, behavioural multiplier model: req 0 sends 0x3FC00000*0x40000000 (1.5*2.0) → rsp_valid[0] rises 4 cycles after accept, rsp_data[0]=0x40400000 (3.0).
- All 4 requesters valid in the same cycle after reset → grants in order 0,1,2,3 on consecutive cycles; each result appears on its own channel with the correct product, no crossover.
- Rotation: req 1 and req 3 continuously valid, last_gnt=1 → next grant 3, then 1 once req 1 returns to IDLE; no requester waits more than N_REQ-1 grants.
- Backpressure: req 2 result with rsp_ready[2]=0 for 10 cycles → rsp_valid[2] and rsp_data[2] held, req_ready[2] stays 0 even with req_valid[2]=1; other requesters keep issuing.
- Reset mid-flight: rst for 1 cycle with 3 ops in flight → all rsp_valid stay 0 afterwards, even as the old products emerge from the multiplier; the first post-reset op is granted to requester 0.
- With FPMUL_ARB_STATS_EN defined: 8 ops issued with 5 contention cycles → issue_cnt=8, stall_cnt=5.

Source files
------------

// File: rtl/fpmul_rr_arbiter_if.sv
// Bundles the per-requester request/response channels and the shared multiplier port.
// The arbiter uses the slave modport; the driving environment uses master.
interface fpmul_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [N_REQ*DW-1:0] rsp_data;
  logic [DW-1:0]       mul_a;
  logic [DW-1:0]       mul_b;
  logic [DW-1:0]       mul_z;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_z,
    output req_ready, rsp_valid, rsp_data, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_z,
    input  req_ready, rsp_valid, rsp_data, mul_a, mul_b
  );
endinterface

// File: rtl/fpmul_rr_arbiter.sv
// Round-robin sharing of one fixed-latency FP multiplier among N_REQ requesters.
// Define FPMUL_ARB_STATS_EN to add issue/stall counters and a per-capture trace line.
module fpmul_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 32,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  fpmul_rr_arbiter_if.slave bus
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [31:0]       issue_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_INFLIGHT, ST_HOLD} state_e;

  state_e              state_q [N_REQ];
  state_e              state_d [N_REQ];
  logic [IW-1:0]       last_gnt_q, last_gnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [N_REQ*DW-1:0] rsp_data_q, rsp_data_d;
  logic [DW-1:0]       mul_a_q, mul_a_d;
  logic [DW-1:0]       mul_b_q, mul_b_d;
  logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]       tag_idx_q [PIPE_LAT];
  logic [IW-1:0]       tag_idx_d [PIPE_LAT];

  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    req_ready;
  logic                gnt_vld;
  logic [IW-1:0]       gnt_idx;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = (state_q[i] == ST_IDLE) && bus.req_valid[i];
    end
  end

  // Scan starts just after the last winner, so the most recent winner has lowest priority.
  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    gnt_vld   = 1'b0;
    gnt_idx   = last_gnt_q;
    req_ready = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_gnt_q) + k) % N_REQ);
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst) gnt_vld = 1'b0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    logic [IW-1:0] cap_idx;
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    cap_idx     = tag_idx_q[PIPE_LAT-1];

    tag_vld_d[0] = gnt_vld;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < PIPE_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (state_q[i] == ST_HOLD && bus.rsp_ready[i]) begin
        state_d[i]     = ST_IDLE;
        rsp_valid_d[i] = 1'b0;
      end
    end

    // The tag leaving the pipe lines up with mul_z for the op it describes.
    if (tag_vld_q[PIPE_LAT-1]) begin
      state_d[cap_idx]                  = ST_HOLD;
      rsp_valid_d[cap_idx]              = 1'b1;
      rsp_data_d[int'(cap_idx)*DW +: DW] = bus.mul_z;
    end

    if (gnt_vld) begin
      mul_a_d          = bus.req_a[int'(gnt_idx)*DW +: DW];
      mul_b_d          = bus.req_b[int'(gnt_idx)*DW +: DW];
      state_d[gnt_idx] = ST_INFLIGHT;
      last_gnt_d       = gnt_idx;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) state_q[i] <= ST_IDLE;
      last_gnt_q  <= IW'(N_REQ - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
    end
  end

  // NOTE: tag indices are qualified by their valid bit, so this array needs no reset.
  always_ff @(posedge clk) begin
    tag_idx_q <= tag_idx_d;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

`ifdef FPMUL_ARB_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] cyc_q, cyc_d;

  // A stall is any idle requester asking while someone else holds the grant.
  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(gnt_vld);
    stall_cnt_d = stall_cnt_q + 32'(|(eligible & ~req_ready));
    cyc_d       = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
      cyc_q       <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      cyc_q       <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tag_vld_q[PIPE_LAT-1]) begin
      $display("fpmul_rr_arbiter: capture req %0d mul_z=%h (%f) cycle %0d",
               tag_idx_q[PIPE_LAT-1], bus.mul_z, $bitstoshortreal(bus.mul_z), cyc_q);
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
